// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared TileLink-UL opcodes, A-channel FSM states and the
//                size-to-beats helper used by the N:1 arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package tl_pkg;

    // A-channel request opcodes
    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;

    // D-channel response opcodes
    localparam logic [2:0] ACK         = 3'd0;
    localparam logic [2:0] ACK_DATA    = 3'd1;

    // Largest transfer (log2 bytes) that is treated as a multi-beat burst
    localparam int unsigned MAX_BURST_LOG2 = 12;

    typedef enum logic [0:0] {
        A_IDLE  = 1'b0,
        A_BURST = 1'b1
    } a_state_t;

    // Beats minus one for a message of 2^size bytes on a bus of 2^lane_log2
    // bytes. Messages that fit in one beat, or exceed the burst ceiling,
    // report zero extra beats.
    function automatic logic [11:0] beats_m1(input int unsigned size,
                                             input int unsigned lane_log2);
        logic [11:0] res;
        res = '0;
        if (size > lane_log2 && size <= MAX_BURST_LOG2) begin
            res = 12'((32'd1 << (size - lane_log2)) - 32'd1);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : tl_rr_picker
//  Description : Combinational round-robin picker. Searches upward from the
//                entry after rr_last, wrapping modulo M, for the first request.
//  Revision    : 1.0  initial release
// ============================================================================
module tl_rr_picker #(
    parameter int M  = 2,
    parameter int IW = $clog2(M)
) (
    input  logic [M-1:0]  req,
    input  logic [IW-1:0] rr_last,
    output logic [IW-1:0] grant_idx,
    output logic [M-1:0]  grant_oh,
    output logic          req_any
);

    logic [IW-1:0] w_cand;

    // Walk candidates farthest-first so the nearest requester overwrites the rest
    always_comb begin
        grant_idx = IW'((int'(rr_last) + 1) % M);
        grant_oh  = '0;
        req_any   = 1'b0;
        w_cand    = '0;
        for (int off = M; off >= 1; off--) begin
            w_cand = IW'((int'(rr_last) + off) % M);
            if (req[w_cand]) begin
                grant_idx = w_cand;
                grant_oh  = M'(1) << w_cand;
                req_any   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tilelink_nto1_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tilelink_nto1_arbiter
//  Description : Merges M TileLink-UL masters onto one A/D port pair.
//                A: round-robin, grant locked across multi-beat Puts, master
//                index prepended to source. D: routed by top source bits.
//                One register stage in each direction.
//  Revision    : 1.0  initial release
// ============================================================================
module tilelink_nto1_arbiter
    import tl_pkg::*;
#(
    parameter  int M     = 2,
    parameter  int TL_DW = 32,
    parameter  int TL_AW = 32,
    parameter  int TL_RS = 4,
    parameter  int TL_SZ = 4,
    localparam int IW    = $clog2(M),
    localparam int MS_RS = TL_RS - IW
) (
    input  logic                    tilelink_clock_i,
    input  logic                    tilelink_reset_i,
    input  logic [3*M-1:0]          master_a_opcode,
    input  logic [3*M-1:0]          master_a_param,
    input  logic [TL_SZ*M-1:0]      master_a_size,
    input  logic [MS_RS*M-1:0]      master_a_source,
    input  logic [TL_AW*M-1:0]      master_a_address,
    input  logic [(TL_DW/8)*M-1:0]  master_a_mask,
    input  logic [TL_DW*M-1:0]      master_a_data,
    input  logic [M-1:0]            master_a_corrupt,
    input  logic [M-1:0]            master_a_valid,
    output logic [M-1:0]            master_a_ready,
    output logic [3*M-1:0]          master_d_opcode,
    output logic [2*M-1:0]          master_d_param,
    output logic [TL_SZ*M-1:0]      master_d_size,
    output logic [MS_RS*M-1:0]      master_d_source,
    output logic [M-1:0]            master_d_denied,
    output logic [M-1:0]            master_d_corrupt,
    output logic [M-1:0]            master_d_valid,
    output logic [TL_DW*M-1:0]      master_d_data,
    input  logic [M-1:0]            master_d_ready,
    output logic [2:0]              slave_a_opcode,
    output logic [2:0]              slave_a_param,
    output logic [TL_SZ-1:0]        slave_a_size,
    output logic [TL_RS-1:0]        slave_a_source,
    output logic [TL_AW-1:0]        slave_a_address,
    output logic [TL_DW/8-1:0]      slave_a_mask,
    output logic [TL_DW-1:0]        slave_a_data,
    output logic                    slave_a_corrupt,
    output logic                    slave_a_valid,
    input  logic                    slave_a_ready,
    input  logic [2:0]              slave_d_opcode,
    input  logic [1:0]              slave_d_param,
    input  logic [TL_SZ-1:0]        slave_d_size,
    input  logic [TL_RS-1:0]        slave_d_source,
    input  logic                    slave_d_denied,
    input  logic                    slave_d_corrupt,
    input  logic                    slave_d_valid,
    input  logic [TL_DW-1:0]        slave_d_data,
    output logic                    slave_d_ready
);

    localparam int          MW        = TL_DW / 8;
    localparam int unsigned LANE_LOG2 = $clog2(MW);

    // ---------------------------------------------------------------- A side
    logic [2:0]       w_a_opcode  [M];
    logic [2:0]       w_a_param   [M];
    logic [TL_SZ-1:0] w_a_size    [M];
    logic [MS_RS-1:0] w_a_source  [M];
    logic [TL_AW-1:0] w_a_address [M];
    logic [MW-1:0]    w_a_mask    [M];
    logic [TL_DW-1:0] w_a_data    [M];

    for (genvar gi = 0; gi < M; gi++) begin : g_a_unpack
        assign w_a_opcode[gi]  = master_a_opcode[gi*3 +: 3];
        assign w_a_param[gi]   = master_a_param[gi*3 +: 3];
        assign w_a_size[gi]    = master_a_size[gi*TL_SZ +: TL_SZ];
        assign w_a_source[gi]  = master_a_source[gi*MS_RS +: MS_RS];
        assign w_a_address[gi] = master_a_address[gi*TL_AW +: TL_AW];
        assign w_a_mask[gi]    = master_a_mask[gi*MW +: MW];
        assign w_a_data[gi]    = master_a_data[gi*TL_DW +: TL_DW];
    end

    a_state_t      r_state, w_state_nxt;
    logic [11:0]   r_cnt, w_cnt_nxt;
    logic [IW-1:0] r_lock, w_lock_nxt;
    logic [IW-1:0] r_rr_last, w_rr_nxt;

    logic [IW-1:0] w_pick_idx;
    logic [M-1:0]  w_pick_oh;
    logic          w_pick_any;
    logic [IW-1:0] w_sel;
    logic [M-1:0]  w_sel_oh;
    logic          w_a_free;
    logic          w_a_hs;
    logic          w_is_put;
    logic [11:0]   w_bm1;

    tl_rr_picker #(.M(M), .IW(IW)) u_picker (
        .req       (master_a_valid),
        .rr_last   (r_rr_last),
        .grant_idx (w_pick_idx),
        .grant_oh  (w_pick_oh),
        .req_any   (w_pick_any)
    );

    assign w_a_free = !slave_a_valid || slave_a_ready;
    assign w_sel    = (r_state == A_BURST) ? r_lock : w_pick_idx;

    // During a burst only the locked master may proceed; otherwise the picker decides
    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < M; i++) begin
            w_sel_oh[i] = (r_state == A_BURST) ? (r_lock == IW'(i))
                                               : (w_pick_oh[i] && w_pick_any);
        end
    end

    assign master_a_ready = w_a_free ? w_sel_oh : '0;
    assign w_a_hs         = |(master_a_valid & master_a_ready);
    assign w_is_put       = (w_a_opcode[w_sel] == PUT_FULL) ||
                            (w_a_opcode[w_sel] == PUT_PARTIAL);
    assign w_bm1          = beats_m1(int'(w_a_size[w_sel]), LANE_LOG2);

    // Next-state logic: open a burst on a multi-beat Put, close it on the last beat
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lock_nxt  = r_lock;
        w_rr_nxt    = r_rr_last;
        case (r_state)
            A_IDLE: begin
                if (w_a_hs) begin
                    w_rr_nxt = w_sel;
                    if (w_is_put && (w_bm1 != '0)) begin
                        w_cnt_nxt   = w_bm1 - 12'd1;
                        w_lock_nxt  = w_sel;
                        w_state_nxt = A_BURST;
                    end
                end
            end
            A_BURST: begin
                if (w_a_hs) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = A_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 12'd1;
                    end
                end
            end
            default: w_state_nxt = A_IDLE;
        endcase
    end

    // A control state and output-stage valid; rr_last resets so master 0 wins first
    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
        if (!tilelink_reset_i) begin
            r_state       <= A_IDLE;
            r_cnt         <= '0;
            r_lock        <= '0;
            r_rr_last     <= IW'(M - 1);
            slave_a_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lock    <= w_lock_nxt;
            r_rr_last <= w_rr_nxt;
            if (w_a_hs) begin
                slave_a_valid <= 1'b1;
            end else if (w_a_free) begin
                slave_a_valid <= 1'b0;
            end
        end
    end

    // A payload stage, tagged with the granted master index in the top source bits
    always_ff @(posedge tilelink_clock_i) begin
        if (w_a_hs) begin
            slave_a_opcode  <= w_a_opcode[w_sel];
            slave_a_param   <= w_a_param[w_sel];
            slave_a_size    <= w_a_size[w_sel];
            slave_a_source  <= {w_sel, w_a_source[w_sel]};
            slave_a_address <= w_a_address[w_sel];
            slave_a_mask    <= w_a_mask[w_sel];
            slave_a_data    <= w_a_data[w_sel];
            slave_a_corrupt <= master_a_corrupt[w_sel];
        end
    end

    // ---------------------------------------------------------------- D side
    logic [IW-1:0] w_d_idx;
    logic [M-1:0]  w_d_dec;
    logic [M-1:0]  w_slot_free;
    logic [M-1:0]  w_d_load;

    assign w_d_idx = slave_d_source[TL_RS-1 -: IW];

    // Decode the destination slot and whether that slot can take a beat
    always_comb begin
        w_d_dec     = '0;
        w_slot_free = '0;
        for (int i = 0; i < M; i++) begin
            w_d_dec[i]     = (w_d_idx == IW'(i));
            w_slot_free[i] = !master_d_valid[i] || master_d_ready[i];
        end
    end

    // An index with no matching master is swallowed so the downstream never stalls
    assign slave_d_ready = (|w_d_dec) ? |(w_d_dec & w_slot_free) : 1'b1;
    assign w_d_load      = {M{slave_d_valid && slave_d_ready}} & w_d_dec;

    // Per-master D valid: a load wins over a simultaneous drain
    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
        if (!tilelink_reset_i) begin
            master_d_valid <= '0;
        end else begin
            for (int i = 0; i < M; i++) begin
                if (w_d_load[i]) begin
                    master_d_valid[i] <= 1'b1;
                end else if (master_d_ready[i]) begin
                    master_d_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Per-master D payload, with the master-index bits stripped from source
    always_ff @(posedge tilelink_clock_i) begin
        for (int i = 0; i < M; i++) begin
            if (w_d_load[i]) begin
                master_d_opcode[i*3 +: 3]         <= slave_d_opcode;
                master_d_param[i*2 +: 2]          <= slave_d_param;
                master_d_size[i*TL_SZ +: TL_SZ]   <= slave_d_size;
                master_d_source[i*MS_RS +: MS_RS] <= slave_d_source[MS_RS-1:0];
                master_d_denied[i]                <= slave_d_denied;
                master_d_corrupt[i]               <= slave_d_corrupt;
                master_d_data[i*TL_DW +: TL_DW]   <= slave_d_data;
            end
        end
    end

endmodule
`default_nettype wire
